event_counter_bank: RTL and testbench

- Bank of NUM_CH independent WIDTH-bit event counters with per-channel increment and clear strobes.
- Each channel has a sticky overflow flag, selectable wrap or saturate mode, and a registered read port with valid/ready handshake and optional clear-on-read.
- A sequential clear-all sweep FSM is included.
- Successor to the single-channel counter logic in the datapath; used for status and statistics collection next to stream blocks.

---
 rtl/event_counter_bank.sv | 198 +++++++++++++++++++
 tb/tb_event_counter_bank.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_counter_bank.sv
// event_counter_bank: NUM_CH independent WIDTH-bit event counters.
// Each channel has a sticky overflow flag and wrap or saturate behaviour.
// A registered read port with a valid/ready handshake supports optional
// clear-on-read, and a sweep FSM clears one channel per cycle.
// Optional feature macro: EVENT_COUNTER_BANK_SNAPSHOT_EN adds snap_i and
// shadow registers, and reads then return the shadow copy.
module event_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 0,
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_CH-1:0]  inc_i,
  input  logic [NUM_CH-1:0]  clr_i,
  input  logic               clr_all_i,
  output logic               busy_o,
  input  logic               rd_req_i,
  input  logic [CH_BITS-1:0] rd_ch_i,
  input  logic               rd_clr_i,
  output logic               rd_ready_o,
  output logic               rd_valid_o,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               rd_ovf_o,
  output logic               rd_err_o,
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
  input  logic               snap_i,
`endif
  output logic [NUM_CH-1:0]  ovf_o
);

  // An illegal width or channel count instantiates a module that does not exist,
  // so elaboration stops here.
  generate
    if (WIDTH < 1 || NUM_CH < 1) begin : g_param_check
      event_counter_bank_illegal_parameters u_illegal ();
    end
  endgenerate

  typedef enum logic {IDLE, SWEEP} state_e;

  localparam logic [WIDTH-1:0] MaxCount = '1;

  state_e             state_q, state_d;
  logic [CH_BITS-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]   cnt_q [NUM_CH];
  logic [WIDTH-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  ovf_q, ovf_d;

  logic               rdValid_q;
  logic [WIDTH-1:0]   rdData_q;
  logic               rdOvf_q;
  logic               rdErr_q;

  logic               rdReady;
  logic               rdAccept;
  logic               rdInRange;
  logic [NUM_CH-1:0]  rdSel;
  logic [WIDTH-1:0]   rdSrcCnt;
  logic               rdSrcOvf;

`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
  logic [WIDTH-1:0]   shdCnt_q [NUM_CH];
  logic [NUM_CH-1:0]  shdOvf_q;
`endif

  assign rdReady  = (state_q == IDLE);
  assign rdAccept = rd_req_i && rdReady;

  // Decode the requested channel and pick the value a read would return.
  always_comb begin
    rdSel    = '0;
    rdSrcCnt = '0;
    rdSrcOvf = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_i == CH_BITS'(c)) begin
        rdSel[c] = 1'b1;
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
        rdSrcCnt = shdCnt_q[c];
        rdSrcOvf = shdOvf_q[c];
`else
        rdSrcCnt = cnt_q[c];
        rdSrcOvf = ovf_q[c];
`endif
      end
    end
    rdInRange = |rdSel;
  end

  // Per-channel next value: sweep clear, then clr_i, then clear-on-read, then increment.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      ovf_d[c] = ovf_q[c];
      if ((state_q == SWEEP) && (idx_q == CH_BITS'(c))) begin
        cnt_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (clr_i[c]) begin
        cnt_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (rdAccept && rd_clr_i && rdSel[c]) begin
        cnt_d[c] = inc_i[c] ? WIDTH'(1) : '0;
        ovf_d[c] = 1'b0;
      end else if (inc_i[c]) begin
        if (cnt_q[c] == MaxCount) begin
          cnt_d[c] = (SATURATE != 0) ? MaxCount : '0;
          ovf_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end
      end
    end
  end

  // Sweep FSM next state: walk idx from 0 to NUM_CH-1, one channel per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_all_i) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == CH_BITS'(NUM_CH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CH_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Counters, flags, FSM state and the registered read response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ovf_q     <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      rdOvf_q   <= 1'b0;
      rdErr_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      if (rdAccept) begin
        rdValid_q <= 1'b1;
        rdErr_q   <= !rdInRange;
        rdData_q  <= rdInRange ? rdSrcCnt : '0;
        rdOvf_q   <= rdInRange && rdSrcOvf;
      end else begin
        rdValid_q <= 1'b0;
      end
    end
  end

`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
  // Shadow copy of counters and flags; the sweep leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shdOvf_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shdCnt_q[c] <= '0;
      end
    end else if (snap_i) begin
      shdOvf_q <= ovf_q;
      for (int c = 0; c < NUM_CH; c++) begin
        shdCnt_q[c] <= cnt_q[c];
      end
    end
  end
`endif

  assign busy_o     = (state_q == SWEEP);
  assign rd_ready_o = rdReady;
  assign rd_valid_o = rdValid_q;
  assign rd_data_o  = rdData_q;
  assign rd_ovf_o   = rdOvf_q;
  assign rd_err_o   = rdErr_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Testbench for event_counter_bank. It drives three instances from one stimulus stream:
//   A: WIDTH=8, NUM_CH=4, wrap
//   B: WIDTH=8, NUM_CH=4, saturate
//   C: WIDTH=8, NUM_CH=3, wrap
// An integer model tracks every instance and is compared on each cycle.
// Literal expectations pin the main scenarios.
module tb_event_counter_bank;

  logic       clk;
  logic       rst;
  logic [3:0] inc;
  logic [3:0] clr;
  logic       clrAll;
  logic       rdReq;
  logic [1:0] rdCh;
  logic       rdClr;
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
  logic       snap;
`endif

  logic       busyW  [3];
  logic       readyW [3];
  logic       validW [3];
  logic [7:0] dataW  [3];
  logic       rdOvfW [3];
  logic       errW   [3];
  logic [3:0] ovfA, ovfB;
  logic [2:0] ovfC;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 0;

  int nCh [3] = '{4, 4, 3};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};

  int mCnt   [3][4];
  bit mOvf   [3][4];
  int mShCnt [3][4];
  bit mShOvf [3][4];
  bit mSweep [3];
  int mIdx   [3];
  bit mValid [3];
  int mData  [3];
  bit mRdOvf [3];
  bit mErr   [3];
  bit acc;
  int ch;

  event_counter_bank #(.WIDTH(8), .NUM_CH(4), .SATURATE(0)) dutA (
    .clk_i(clk), .rst_i(rst), .inc_i(inc), .clr_i(clr), .clr_all_i(clrAll),
    .busy_o(busyW[0]), .rd_req_i(rdReq), .rd_ch_i(rdCh), .rd_clr_i(rdClr),
    .rd_ready_o(readyW[0]), .rd_valid_o(validW[0]), .rd_data_o(dataW[0]),
    .rd_ovf_o(rdOvfW[0]), .rd_err_o(errW[0]),
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
    .snap_i(snap),
`endif
    .ovf_o(ovfA));

  event_counter_bank #(.WIDTH(8), .NUM_CH(4), .SATURATE(1)) dutB (
    .clk_i(clk), .rst_i(rst), .inc_i(inc), .clr_i(clr), .clr_all_i(clrAll),
    .busy_o(busyW[1]), .rd_req_i(rdReq), .rd_ch_i(rdCh), .rd_clr_i(rdClr),
    .rd_ready_o(readyW[1]), .rd_valid_o(validW[1]), .rd_data_o(dataW[1]),
    .rd_ovf_o(rdOvfW[1]), .rd_err_o(errW[1]),
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
    .snap_i(snap),
`endif
    .ovf_o(ovfB));

  event_counter_bank #(.WIDTH(8), .NUM_CH(3), .SATURATE(0)) dutC (
    .clk_i(clk), .rst_i(rst), .inc_i(inc[2:0]), .clr_i(clr[2:0]), .clr_all_i(clrAll),
    .busy_o(busyW[2]), .rd_req_i(rdReq), .rd_ch_i(rdCh), .rd_clr_i(rdClr),
    .rd_ready_o(readyW[2]), .rd_valid_o(validW[2]), .rd_data_o(dataW[2]),
    .rd_ovf_o(rdOvfW[2]), .rd_err_o(errW[2]),
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
    .snap_i(snap),
`endif
    .ovf_o(ovfC));

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] i, input logic [3:0] c, input logic ca,
                               input logic rq, input logic [1:0] rc, input logic rcl);
    inc    = i;
    clr    = c;
    clrAll = ca;
    rdReq  = rq;
    rdCh   = rc;
    rdClr  = rcl;
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
    snap   = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic snapIfEnabled();
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
    inc = '0; clr = '0; clrAll = 1'b0; rdReq = 1'b0; rdCh = '0; rdClr = 1'b0;
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
`endif
  endtask

  // Reference model: plain integer counters updated from the sampled inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int c = 0; c < 4; c++) begin
          mCnt[k][c] = 0; mOvf[k][c] = 0; mShCnt[k][c] = 0; mShOvf[k][c] = 0;
        end
        mSweep[k] = 0; mIdx[k] = 0; mValid[k] = 0;
        mData[k] = 0; mRdOvf[k] = 0; mErr[k] = 0;
      end else begin
        acc = rdReq && !mSweep[k];
        ch  = int'(rdCh);
        if (acc) begin
          mValid[k] = 1;
          if (ch < nCh[k]) begin
            mErr[k] = 0;
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
            mData[k] = mShCnt[k][ch]; mRdOvf[k] = mShOvf[k][ch];
`else
            mData[k] = mCnt[k][ch];   mRdOvf[k] = mOvf[k][ch];
`endif
          end else begin
            mErr[k] = 1; mData[k] = 0; mRdOvf[k] = 0;
          end
        end else begin
          mValid[k] = 0;
        end
`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
        if (snap) begin
          for (int c = 0; c < 4; c++) begin
            mShCnt[k][c] = mCnt[k][c]; mShOvf[k][c] = mOvf[k][c];
          end
        end
`endif
        for (int c = 0; c < nCh[k]; c++) begin
          if (mSweep[k] && mIdx[k] == c) begin
            mCnt[k][c] = 0; mOvf[k][c] = 0;
          end else if (clr[c]) begin
            mCnt[k][c] = 0; mOvf[k][c] = 0;
          end else if (acc && rdClr && ch == c) begin
            mCnt[k][c] = inc[c] ? 1 : 0; mOvf[k][c] = 0;
          end else if (inc[c]) begin
            if (mCnt[k][c] + 1 > 255) begin
              mOvf[k][c] = 1;
              mCnt[k][c] = sat[k] ? 255 : 0;
            end else begin
              mCnt[k][c] = mCnt[k][c] + 1;
            end
          end
        end
        if (mSweep[k]) begin
          if (mIdx[k] == nCh[k] - 1) mSweep[k] = 0;
          else mIdx[k] = mIdx[k] + 1;
        end else if (clrAll) begin
          mSweep[k] = 1; mIdx[k] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0] expOvf;
        logic [3:0] actOvf;
        expOvf = '0;
        for (int c = 0; c < nCh[k]; c++) expOvf[c] = mOvf[k][c];
        actOvf = (k == 0) ? ovfA : (k == 1) ? ovfB : {1'b0, ovfC};
        checkOutput($sformatf("dut%0d.busy", k),  32'(busyW[k]),  32'(mSweep[k]));
        checkOutput($sformatf("dut%0d.ready", k), 32'(readyW[k]), 32'(!mSweep[k]));
        checkOutput($sformatf("dut%0d.valid", k), 32'(validW[k]), 32'(mValid[k]));
        checkOutput($sformatf("dut%0d.data", k),  32'(dataW[k]),  32'(mData[k]));
        checkOutput($sformatf("dut%0d.rdovf", k), 32'(rdOvfW[k]), 32'(mRdOvf[k]));
        checkOutput($sformatf("dut%0d.ovf", k),   32'(actOvf),    32'(expOvf));
        if (mValid[k]) checkOutput($sformatf("dut%0d.err", k), 32'(errW[k]), 32'(mErr[k]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(4'h0, 4'h0, 0, 0, 2'd0, 0);
    applyStimulus(4'h0, 4'h0, 0, 0, 2'd0, 0);
    cmpEn = 1;
    rst = 1'b0;
    checkOutput("lit.reset.ready", 32'(readyW[0]), 32'd1);
    checkOutput("lit.reset.busy",  32'(busyW[0]),  32'd0);
    checkOutput("lit.reset.data",  32'(dataW[0]),  32'd0);
    applyStimulus(4'h0, 4'h0, 0, 0, 2'd0, 0);

    // 256 increments on channel 1: wraps on A, saturates on B.
    repeat (256) applyStimulus(4'b0010, 4'h0, 0, 0, 2'd0, 0);
    checkOutput("lit.wrap.ovfo", 32'(ovfA[1]), 32'd1);
    snapIfEnabled();
    applyStimulus(4'h0, 4'h0, 0, 1, 2'd1, 0);
    checkOutput("lit.wrap.valid", 32'(validW[0]), 32'd1);
    checkOutput("lit.wrap.data",  32'(dataW[0]),  32'h00);
    checkOutput("lit.wrap.rdovf", 32'(rdOvfW[0]), 32'd1);
    checkOutput("lit.sat256.data", 32'(dataW[1]), 32'hFF);
    applyStimulus(4'h0, 4'h0, 0, 0, 2'd0, 0);
    checkOutput("lit.wrap.sticky", 32'(ovfA[1]), 32'd1);
    applyStimulus(4'h0, 4'b0010, 0, 0, 2'd0, 0);
    checkOutput("lit.wrap.cleared", 32'(ovfA[1]), 32'd0);

    // 300 increments on channel 2.
    repeat (300) applyStimulus(4'b0100, 4'h0, 0, 0, 2'd0, 0);
    snapIfEnabled();
    applyStimulus(4'h0, 4'h0, 0, 1, 2'd2, 0);
    checkOutput("lit.ch2wrap.data", 32'(dataW[0]), 32'd44);
    checkOutput("lit.sat.data",     32'(dataW[1]), 32'hFF);
    checkOutput("lit.sat.rdovf",    32'(rdOvfW[1]), 32'd1);

    // Clear-on-read together with increment.
    applyStimulus(4'h0, 4'b0001, 0, 0, 2'd0, 0);
    repeat (5) applyStimulus(4'b0001, 4'h0, 0, 0, 2'd0, 0);
    snapIfEnabled();
    applyStimulus(4'b0001, 4'h0, 0, 1, 2'd0, 1);
    checkOutput("lit.cor.data", 32'(dataW[0]), 32'd5);
    snapIfEnabled();
    applyStimulus(4'h0, 4'h0, 0, 1, 2'd0, 0);
    checkOutput("lit.cor.after", 32'(dataW[0]), 32'd1);

    // Sweep with channel 3 incrementing throughout and a read in the start cycle.
    applyStimulus(4'h0, 4'hF, 0, 0, 2'd0, 0);
    repeat (7) applyStimulus(4'hF, 4'h0, 0, 0, 2'd0, 0);
    snapIfEnabled();
    applyStimulus(4'b1000, 4'h0, 1, 1, 2'd3, 0);
    checkOutput("lit.sweep.rdvalid", 32'(validW[0]), 32'd1);
    checkOutput("lit.sweep.rddata",  32'(dataW[0]),  32'd7);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("lit.sweep.busy%0d", i),  32'(busyW[0]),  32'd1);
      checkOutput($sformatf("lit.sweep.ready%0d", i), 32'(readyW[0]), 32'd0);
      applyStimulus(4'b1000, 4'h0, 0, 1, 2'd0, 0);
      checkOutput($sformatf("lit.sweep.noacc%0d", i), 32'(validW[0]), 32'd0);
    end
    checkOutput("lit.sweep.done", 32'(busyW[0]), 32'd0);
    snapIfEnabled();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'h0, 4'h0, 0, 1, 2'(c), 0);
      checkOutput($sformatf("lit.sweep.ch%0d", c), 32'(dataW[0]), 32'd0);
    end

    // Out-of-range channel on the 3-channel instance.
    applyStimulus(4'h0, 4'h0, 0, 1, 2'd3, 0);
    checkOutput("lit.err.flag",  32'(errW[2]),  32'd1);
    checkOutput("lit.err.data",  32'(dataW[2]), 32'd0);
    checkOutput("lit.err.inA",   32'(errW[0]),  32'd0);

    // Reset in the middle of a sweep.
    repeat (5) applyStimulus(4'hF, 4'h0, 0, 0, 2'd0, 0);
    applyStimulus(4'h0, 4'h0, 1, 0, 2'd0, 0);
    applyStimulus(4'h0, 4'h0, 0, 0, 2'd0, 0);
    rst = 1'b1;
    applyStimulus(4'h0, 4'h0, 0, 0, 2'd0, 0);
    checkOutput("lit.rst.busy", 32'(busyW[0]), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'h0, 4'h0, 0, 1, 2'(c), 0);
      checkOutput($sformatf("lit.rst.ch%0d", c), 32'(dataW[0]), 32'd0);
    end

`ifdef EVENT_COUNTER_BANK_SNAPSHOT_EN
    // Snapshot holds older values while the live counter keeps counting.
    applyStimulus(4'h0, 4'b0001, 0, 0, 2'd0, 0);
    repeat (10) applyStimulus(4'b0001, 4'h0, 0, 0, 2'd0, 0);
    snapIfEnabled();
    repeat (4) applyStimulus(4'b0001, 4'h0, 0, 0, 2'd0, 0);
    applyStimulus(4'h0, 4'h0, 0, 1, 2'd0, 0);
    checkOutput("lit.snap.first", 32'(dataW[0]), 32'd10);
    snapIfEnabled();
    applyStimulus(4'h0, 4'h0, 0, 1, 2'd0, 0);
    checkOutput("lit.snap.second", 32'(dataW[0]), 32'd14);
`endif

    applyStimulus(4'h0, 4'h0, 0, 0, 2'd0, 0);
    cmpEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
